// File: rtl/note_playback_scheduler.sv
// note_playback_scheduler: walks event RAM in address order and strobes each note
// once the microsecond time counter reaches the event timestamp.
module note_playback_scheduler #(
    parameter int ADDR_W   = 9,
    parameter int TIME_W   = 29,
    parameter int NOTE_W   = 7,
    parameter int TIME_MAX = 300000000,
    localparam int EVT_W   = TIME_W + NOTE_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W:0]   num_events,
    input  logic [TIME_W-1:0] current_time,
    output logic              time_enable,
    output logic              time_clear,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [EVT_W-1:0]  mem_rdata,
    output logic              note_valid,
    output logic [NOTE_W-1:0] note_code,
    output logic              note_on,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_DATA, S_ARMED, S_EMIT, S_DONE} state_t;

    localparam logic [TIME_W-1:0] TMAX = TIME_W'(TIME_MAX);

    state_t              r_state, w_state_nx;
    logic [ADDR_W:0]     r_ptr, r_cnt, w_ptr_inc, w_ptr_nx;
    logic [EVT_W-1:0]    r_evt;
    logic                w_start_ok, w_active, w_abort, w_run_nx;
    logic                r_time_enable, r_time_clear, r_mem_rd_en, r_note_valid;
    logic                r_note_on, r_busy, r_done, r_aborted;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [NOTE_W-1:0]   r_note_code;

    assign w_start_ok = (r_state == S_IDLE) && start && !stop;
    assign w_active   = r_state inside {S_FETCH, S_WAIT_DATA, S_ARMED, S_EMIT};
    assign w_abort    = stop && w_active;
    assign w_ptr_inc  = r_ptr + (ADDR_W+1)'(1);
    assign w_ptr_nx   = w_start_ok ? '0 : (r_state == S_EMIT) ? w_ptr_inc : r_ptr;
    assign w_run_nx   = w_state_nx inside {S_FETCH, S_WAIT_DATA, S_ARMED, S_EMIT};

    // stop takes priority over every forward transition while playing
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:      w_state_nx = !w_start_ok ? S_IDLE : (num_events == '0) ? S_DONE : S_FETCH;
            S_FETCH:     w_state_nx = stop ? S_IDLE : S_WAIT_DATA;
            S_WAIT_DATA: w_state_nx = stop ? S_IDLE : (mem_rdata[TIME_W-1:0] > TMAX) ? S_DONE : S_ARMED;
            S_ARMED:     w_state_nx = stop ? S_IDLE : (current_time >= r_evt[TIME_W-1:0]) ? S_EMIT : S_ARMED;
            S_EMIT:      w_state_nx = stop ? S_IDLE : (w_ptr_inc == r_cnt) ? S_DONE : S_FETCH;
            default:     w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_evt         <= '0;
            r_time_enable <= 1'b0;
            r_time_clear  <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_addr    <= '0;
            r_note_valid  <= 1'b0;
            r_note_code   <= '0;
            r_note_on     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_ptr         <= w_ptr_nx;
            if (w_start_ok) r_cnt <= num_events;
            if (r_state == S_WAIT_DATA) r_evt <= mem_rdata;
            r_time_enable <= w_run_nx;
            r_time_clear  <= w_start_ok;
            r_mem_rd_en   <= w_state_nx == S_FETCH;
            if (w_state_nx == S_FETCH) r_mem_addr <= w_ptr_nx[ADDR_W-1:0];
            r_note_valid  <= w_state_nx == S_EMIT;
            if (w_state_nx == S_EMIT) {r_note_on, r_note_code} <= r_evt[EVT_W-1:TIME_W];
            r_busy        <= w_state_nx != S_IDLE;
            r_done        <= w_state_nx == S_DONE;
            r_aborted     <= w_abort;
        end
    end

    assign time_enable = r_time_enable;
    assign time_clear  = r_time_clear;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = r_mem_addr;
    assign note_valid  = r_note_valid;
    assign note_code   = r_note_code;
    assign note_on     = r_note_on;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
endmodule

// File: tb/tb_note_playback_scheduler.sv
// tb_note_playback_scheduler: directed and randomized playback runs checked against
// a cycle schedule computed from timestamps, plus abort and async reset cases.
module tb_note_playback_scheduler;
    localparam int ADDR_W   = 9;
    localparam int TIME_W   = 29;
    localparam int NOTE_W   = 7;
    localparam int EVT_W    = TIME_W + NOTE_W + 1;
    localparam int TIME_MAX = 300000000;

    logic              clk = 1'b0, resetn = 1'b1, start = 1'b0, stop = 1'b0;
    logic [ADDR_W:0]   num_events = '0;
    logic [TIME_W-1:0] current_time = '0;
    logic [EVT_W-1:0]  mem_rdata = '0;
    logic              time_enable, time_clear, mem_rd_en, note_valid, note_on, busy, done, aborted;
    logic [ADDR_W-1:0] mem_addr;
    logic [NOTE_W-1:0] note_code;
    logic [EVT_W-1:0]  mem [0:511];
    int checks = 0, errors = 0;

    note_playback_scheduler dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .num_events(num_events),
        .current_time(current_time), .time_enable(time_enable), .time_clear(time_clear),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .note_valid(note_valid), .note_code(note_code), .note_on(note_on),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // microsecond counter and 1-cycle-latency event RAM
    always @(posedge clk) begin
        if (time_clear) current_time <= '0;
        else if (time_enable) current_time <= current_time + 1'b1;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_evt(input int idx, input bit on, input int code, input int ts);
        mem[idx] = {on, NOTE_W'(code), TIME_W'(ts)};
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".vec"}, {time_enable, time_clear, mem_rd_en, note_valid, note_on, busy, done, aborted}, 0);
        chk({tag, ".addr"}, mem_addr, 0);
        chk({tag, ".code"}, note_code, 0);
    endtask

    // Schedule: fetch at cycle f (f=1 after start), armed at f+2 with time(c)=c-2,
    // emit one cycle after the first armed cycle whose time reaches the timestamp.
    task automatic play(input int n, input bit inject_start);
        int fetch_c[$], emit_c[$];
        int cur, done_c, ts, e, ke, kf;
        bit term, exp_v, exp_f;
        cur = 1; done_c = 1; term = 0;
        for (int i = 0; i < n; i++) begin
            if (!term) begin
                fetch_c.push_back(cur);
                ts = int'(mem[i][TIME_W-1:0]);
                if (ts > TIME_MAX) begin
                    done_c = cur + 2;
                    term = 1;
                end else begin
                    e = ((cur + 2 > ts + 2) ? cur + 2 : ts + 2) + 1;
                    emit_c.push_back(e);
                    cur = e + 1;
                    done_c = e + 1;
                end
            end
        end
        num_events = (ADDR_W+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        ke = 0; kf = 0;
        for (int c = 1; c <= done_c + 1; c++) begin
            exp_v = ke < emit_c.size() && c == emit_c[ke];
            exp_f = kf < fetch_c.size() && c == fetch_c[kf];
            chk("note_valid", note_valid, exp_v);
            if (exp_v) begin
                chk("note_code", note_code, mem[ke][TIME_W+NOTE_W-1:TIME_W]);
                chk("note_on", note_on, mem[ke][EVT_W-1]);
                ke++;
            end
            chk("mem_rd_en", mem_rd_en, exp_f);
            if (exp_f) begin
                chk("mem_addr", mem_addr, kf);
                kf++;
            end
            chk("done", done, c == done_c);
            chk("busy", busy, c <= done_c);
            chk("time_enable", time_enable, c < done_c);
            chk("time_clear", time_clear, c == 1);
            chk("aborted", aborted, 0);
            if (inject_start && c == 2 && done_c >= 2) start = 1'b1;
            if (c <= done_c) begin
                tick();
                start = 1'b0;
            end
        end
    endtask

    initial begin
        int n;
        bit found;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        tick(); tick();
        chk_all_zero("reset_hold");
        resetn = 1'b0;
        tick();
        chk_all_zero("reset_release");

        set_evt(0, 1, 60, 0); set_evt(1, 0, 60, 10); set_evt(2, 1, 64, 25);
        play(3, 1);
        play(0, 0);
        set_evt(0, 1, 62, 5); set_evt(1, 1, 63, TIME_MAX + 1);
        play(2, 0);
        for (int i = 0; i < 4; i++) set_evt(i, 1, 60 + i, 5);
        play(4, 0);

        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++)
                set_evt(i, 1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0)
                set_evt($urandom_range(0, n - 1), 1, 1, TIME_MAX + 1 + $urandom_range(0, 1000));
            play(n, 1'($urandom_range(0, 1)));
        end

        // abort while armed on a far timestamp
        set_evt(0, 1, 70, 1000);
        num_events = 1; start = 1'b1; tick(); start = 1'b0;
        repeat (401) tick();
        chk("abort.time", current_time, 400);
        chk("abort.busy_before", busy, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("abort.aborted", aborted, 1);
        chk("abort.note_valid", note_valid, 0);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.time_enable", time_enable, 0);
        tick();
        chk("abort.aborted_pulse", aborted, 0);
        chk("abort.done_after", done, 0);

        // abort cancels an emit that is already due
        set_evt(0, 1, 71, 0);
        num_events = 1; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("abort_due.note_valid", note_valid, 0);
        chk("abort_due.aborted", aborted, 1);
        tick();
        chk("abort_due.no_late_note", note_valid, 0);

        // stop wins over start in idle
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("idle_stop.busy", busy, 0);
        chk("idle_stop.time_clear", time_clear, 0);
        chk("idle_stop.mem_rd_en", mem_rd_en, 0);

        // stop in DONE still completes normally
        num_events = 0; start = 1'b1; tick(); start = 1'b0;
        chk("done_stop.done", done, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("done_stop.aborted", aborted, 0);
        chk("done_stop.busy", busy, 0);

        // async reset during EMIT, then replay from address 0
        set_evt(0, 1, 60, 0); set_evt(1, 0, 60, 10); set_evt(2, 1, 64, 25);
        num_events = 3; start = 1'b1; tick(); start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (note_valid) found = 1;
            else tick();
        end
        chk("rst_emit.found", found, 1);
        #2 resetn = 1'b1;
        #1 chk_all_zero("rst_emit");
        @(negedge clk) resetn = 1'b0;
        tick();
        play(3, 0);

        for (int i = 0; i < 512; i++) set_evt(i, i[0], i % 128, i * 4);
        play(512, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
